rbus_tile_sink: RTL and testbench
=================================

Name: rbus_tile_sink

Overview:
- Ring-bus stage directly downstream of the tile's rbus merge stage; consumes its rbusOut_* and drives its next_in_can.
- Extracts packets addressed to this tile (dst_req == ID) into a local receive FIFO.
- Forwards all other traffic, registered, to the next ring stage.
- Multi-beat packets (first beat plus `rbus_second beat) are captured atomically.

Parameters:
- ID, 5'd0, tile ID matched against dst_req (zero-extended to 10 bits).
- DEPTH, 8, receive FIFO entries; power of two, at least 4.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rbusIn_signals  in  `rbus_width  ring signals from upstream merge stage
- rbusIn_src_req  in  10  source requester
- rbusIn_dst_req  in  10  destination requester
- rbusIn_address  in  37  address
- in_can  out  1  to upstream next_in_can; high = upstream may inject new packets
- rbusOut_signals  out  `rbus_width  forwarded ring signals (registered)
- rbusOut_src_req  out  10  forwarded src
- rbusOut_dst_req  out  10  forwarded dst
- rbusOut_address  out  37  forwarded address
- deq_valid  out  1  FIFO head valid
- deq_signals  out  `rbus_width  head signals
- deq_src_req  out  10  head src
- deq_address  out  37  head address
- deq_ready  in  1  local consumer pops the head when deq_valid && deq_ready

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high. Reset mid-operation discards FIFO contents and any partial multi-beat capture.
- Reset values:
  - rbusOut_* = 0.
  - deq_valid = 0.
  - FIFO count, rd/wr pointers = 0.
  - State = IDLE.
  - in_can = 1.
- Hit condition: hit = rbusIn_signals[`rbus_used] && rbusIn_dst_req == {5'b0,ID}. free = DEPTH - count.
- State machine: IDLE, CAPT2.
  - IDLE, hit, `rbus_second clear, free >= 2: write the beat to the FIFO. Go to CAPT2 (a second beat is always reserved). Forward the beat with `rbus_used cleared.
  - IDLE, hit, free < 2: do not capture. Forward the beat unchanged (used still set) so it recirculates. Stay in IDLE.
  - CAPT2, incoming beat has `rbus_second set: write it (space guaranteed), forward with used cleared, go to IDLE.
  - CAPT2, incoming beat lacks `rbus_second (single-beat packet): release the reservation, go to IDLE. That beat is evaluated as an IDLE beat in the same cycle.
  - CAPT2 never lasts more than one cycle.
- Orphan second beat: a `rbus_second beat arriving in IDLE whose first beat was not captured is forwarded unchanged.
- Forward path: rbusOut_* <= rbusIn_* every cycle, 1-cycle latency, no stall. A non-hit beat passes unmodified.
- Backpressure: in_can = (count + writes_this_cycle) <= DEPTH-3, registered. This leaves one multi-beat packet of margin for in-flight traffic.
- Dequeue:
  - deq_* present the FIFO head combinationally from the storage registers; deq_valid = count != 0.
  - Pop and write in the same cycle is legal: count is unchanged and pointers advance independently.
  - Pointers wrap modulo DEPTH.
- Count arithmetic: PTR_W+1 bits. count never exceeds DEPTH by construction. Overflow and underflow are assertion failures.

Optional Feature:
- Macro: RBUS_SINK_STATS_EN.
- With the macro defined:
  - Adds output drop_cnt [15:0], reset to 0.
  - drop_cnt increments by 1 on every IDLE hit rejected for free < 2.
  - Saturates at 16'hFFFF.
- Without the macro: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package (struct.sv), holding:
  - `rbus_width, `rbus_used and `rbus_second bit indices;
  - the tile-ID type;
  - a packet struct of signals/src/dst/address.
- Sub-module rbus_sink_fifo: DEPTH-entry FIFO with count, free output and simultaneous push/pop.
- The top level holds the state machine, hit logic, forward register and in_can.

Test Plan:
- Reset, then a single-beat packet with dst=ID, used=1, addr=37'h1234: deq_valid rises the next cycle with deq_address=37'h1234. rbusOut shows the beat with used=0 one cycle after input.
- Packet with dst=ID+1: forwarded unchanged after 1 cycle; FIFO count remains 0.
- Two-beat packet to ID (beat1 then beat2 with `rbus_second): both land in the FIFO in order (count=2). Both are forwarded with used=0.
- deq_ready=0, fill with 6 single-beat hits (DEPTH=8): in_can drops after the count reaches 6. A 7th hit arriving with free=2 is captured (free≥2 rule). The next hit with free=1 is forwarded with used=1 and, with RBUS_SINK_STATS_EN, drop_cnt=1.
- Push and pop in the same cycle with count=3: count stays 3 and head data advances correctly across pointer wrap (write 10 entries total).
- Assert rst while in CAPT2 with count=5: next cycle count=0, deq_valid=0, in_can=1, rbusOut_*=0.

Source files
------------

// File: rtl/rbus_tile_sink_pkg.sv
// Shared types for the rbus tile sink: ring-signal bit positions, tile ID and packet layouts.
package rbus_tile_sink_pkg;

    localparam int RBUS_WIDTH  = 8;
    localparam int RBUS_USED   = 0;
    localparam int RBUS_SECOND = 1;

    typedef logic [4:0] tile_id_t;

    typedef struct packed {
        logic [RBUS_WIDTH-1:0] signals;
        logic [9:0]            src_req;
        logic [9:0]            dst_req;
        logic [36:0]           address;
    } rbus_pkt_t;

    // Receive FIFO entry: the destination is implied (it is this tile), so it is not stored.
    typedef struct packed {
        logic [RBUS_WIDTH-1:0] signals;
        logic [9:0]            src_req;
        logic [36:0]           address;
    } rbus_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CAPT2 = 1'b1
    } sink_state_t;

endpackage

// File: rtl/rbus_tile_sink_if.sv
// Ring-bus and local dequeue signals of the tile sink; slave = sink side, master = environment side.
interface rbus_tile_sink_if;
    import rbus_tile_sink_pkg::*;

    logic [RBUS_WIDTH-1:0] rbusIn_signals;
    logic [9:0]            rbusIn_src_req;
    logic [9:0]            rbusIn_dst_req;
    logic [36:0]           rbusIn_address;
    logic                  in_can;
    logic [RBUS_WIDTH-1:0] rbusOut_signals;
    logic [9:0]            rbusOut_src_req;
    logic [9:0]            rbusOut_dst_req;
    logic [36:0]           rbusOut_address;
    // deq_* is valid/ready: the head is popped on a cycle where deq_valid && deq_ready;
    // deq_valid never depends on deq_ready and the head stays put until popped.
    logic                  deq_valid;
    logic [RBUS_WIDTH-1:0] deq_signals;
    logic [9:0]            deq_src_req;
    logic [36:0]           deq_address;
    logic                  deq_ready;

    modport slave (
        input  rbusIn_signals, rbusIn_src_req, rbusIn_dst_req, rbusIn_address, deq_ready,
        output in_can, rbusOut_signals, rbusOut_src_req, rbusOut_dst_req, rbusOut_address,
        output deq_valid, deq_signals, deq_src_req, deq_address
    );

    modport master (
        output rbusIn_signals, rbusIn_src_req, rbusIn_dst_req, rbusIn_address, deq_ready,
        input  in_can, rbusOut_signals, rbusOut_src_req, rbusOut_dst_req, rbusOut_address,
        input  deq_valid, deq_signals, deq_src_req, deq_address
    );

endinterface

// File: rtl/rbus_tile_sink_fifo.sv
// Receive FIFO of the tile sink: DEPTH entries, simultaneous push/pop, count and free outputs.
module rbus_sink_fifo
    import rbus_tile_sink_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rbus_entry_t   push_entry,
    input  logic          pop,
    output rbus_entry_t   head,
    output logic [PTR_W:0] count,
    output logic [PTR_W:0] free
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    rbus_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign free = DEPTH_C - count;

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == DEPTH_C));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));

endmodule

// File: rtl/rbus_tile_sink.sv
// Ring-bus tile sink: captures packets addressed to ID into a local FIFO and forwards the ring.
// Optional RBUS_SINK_STATS_EN adds a saturating drop_cnt of hits rejected for lack of space.
module rbus_tile_sink
    import rbus_tile_sink_pkg::*;
#(
    parameter tile_id_t ID    = 5'd0,
    parameter int       DEPTH = 8,
    parameter int       PTR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    rbus_tile_sink_if.slave bus,
    output sink_state_t    state
`ifdef RBUS_SINK_STATS_EN
    ,
    output logic [15:0]    drop_cnt
`endif
);

    localparam logic [PTR_W+1:0] CAN_LIMIT = (PTR_W+2)'(DEPTH - 3);

    sink_state_t    state_n;
    rbus_pkt_t      in_pkt;
    rbus_pkt_t      fwd_pkt;
    rbus_pkt_t      fwd_q;
    rbus_entry_t    head;
    logic [PTR_W:0] count;
    logic [PTR_W:0] free;
    logic           hit;
    logic           second;
    logic           push;
    logic           pop;
    logic           reject;
    logic           in_can_q;
    logic [PTR_W+1:0] fill_n;

    assign in_pkt = '{signals: bus.rbusIn_signals, src_req: bus.rbusIn_src_req,
                      dst_req: bus.rbusIn_dst_req, address: bus.rbusIn_address};
    assign hit    = in_pkt.signals[RBUS_USED] && (in_pkt.dst_req == {5'b0, ID});
    assign second = in_pkt.signals[RBUS_SECOND];
    assign pop    = bus.deq_valid && bus.deq_ready;

    // A captured first beat always reserves a slot, so the second beat never needs a space check.
    // When the expected second beat does not arrive, the beat is judged as a fresh IDLE beat.
    always_comb begin
        state_n = IDLE;
        push    = 1'b0;
        reject  = 1'b0;
        fwd_pkt = in_pkt;
        if (state == CAPT2 && second && hit) begin
            push = 1'b1;
        end else if (hit && !second) begin
            if (free >= (PTR_W+1)'(2)) begin
                push    = 1'b1;
                state_n = CAPT2;
            end else begin
                reject  = 1'b1;
            end
        end
        if (push) fwd_pkt.signals[RBUS_USED] = 1'b0;
    end

    assign fill_n = {1'b0, count} + (PTR_W+2)'(push);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fwd_q    <= '0;
            in_can_q <= 1'b1;
        end else begin
            state    <= state_n;
            fwd_q    <= fwd_pkt;
            in_can_q <= (fill_n <= CAN_LIMIT);
        end
    end

    rbus_sink_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{signals: in_pkt.signals, src_req: in_pkt.src_req, address: in_pkt.address}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .free       (free)
    );

    assign bus.in_can          = in_can_q;
    assign bus.rbusOut_signals = fwd_q.signals;
    assign bus.rbusOut_src_req = fwd_q.src_req;
    assign bus.rbusOut_dst_req = fwd_q.dst_req;
    assign bus.rbusOut_address = fwd_q.address;
    assign bus.deq_valid       = (count != '0);
    assign bus.deq_signals     = head.signals;
    assign bus.deq_src_req     = head.src_req;
    assign bus.deq_address     = head.address;

`ifdef RBUS_SINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (reject && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rbus_tile_sink.sv
// Self-checking bench for rbus_tile_sink: directed scenarios plus randomized ring traffic
// checked every cycle against a queue-based model of the sink's capture/forward rules.
module tb_rbus_tile_sink;
    import rbus_tile_sink_pkg::*;

    localparam int       DEPTH = 8;
    localparam tile_id_t ID    = 5'd0;
    localparam logic [RBUS_WIDTH-1:0] U = (RBUS_WIDTH)'(1) << RBUS_USED;
    localparam logic [RBUS_WIDTH-1:0] S = (RBUS_WIDTH)'(1) << RBUS_SECOND;
    localparam logic [9:0] MY_DST = {5'b0, ID};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rbus_tile_sink_if bus();
    sink_state_t state;
`ifdef RBUS_SINK_STATS_EN
    logic [15:0] drop_cnt;
`endif

    rbus_tile_sink #(.ID(ID), .DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
`ifdef RBUS_SINK_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // Model: expected FIFO contents, whether a second beat is awaited, drop count, registered outputs.
    rbus_entry_t            exp_q[$];
    bit                     waiting_second;
    int                     drop_m;
    logic [RBUS_WIDTH-1:0]  exp_sig;
    logic [9:0]             exp_src;
    logic [9:0]             exp_dst;
    logic [36:0]            exp_addr;
    bit                     exp_can;

    int  n_checks;
    int  n_fail;
    bit  chk_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One ring beat: drive inputs after the falling edge, predict, clock, then commit the prediction.
    task automatic step(input logic [RBUS_WIDTH-1:0] sig, input logic [9:0] src,
                        input logic [9:0] dst, input logic [36:0] addr, input logic rdy);
        int cnt;
        bit hit;
        bit sec;
        bit do_push;
        bit do_pop;
        bit res_n;
        bit drop_n;
        logic [RBUS_WIDTH-1:0] sig_n;
        @(negedge clk);
        #1;
        bus.rbusIn_signals = sig;
        bus.rbusIn_src_req = src;
        bus.rbusIn_dst_req = dst;
        bus.rbusIn_address = addr;
        bus.deq_ready      = rdy;
        cnt     = exp_q.size();
        hit     = sig[RBUS_USED] && (dst == MY_DST);
        sec     = sig[RBUS_SECOND];
        sig_n   = sig;
        do_push = 1'b0;
        res_n   = 1'b0;
        drop_n  = 1'b0;
        if (waiting_second && sec && hit) begin
            do_push = 1'b1;
        end else if (hit && !sec) begin
            if (DEPTH - cnt >= 2) begin
                do_push = 1'b1;
                res_n   = 1'b1;
            end else begin
                drop_n  = 1'b1;
            end
        end
        if (do_push) sig_n[RBUS_USED] = 1'b0;
        do_pop = rdy && (cnt > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            waiting_second = 1'b0;
            drop_m   = 0;
            exp_sig  = '0;
            exp_src  = '0;
            exp_dst  = '0;
            exp_addr = '0;
            exp_can  = 1'b1;
        end else begin
            exp_can = (cnt + int'(do_push)) <= DEPTH - 3;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{signals: sig, src_req: src, address: addr});
            waiting_second = res_n;
            if (drop_n && drop_m < 16'hFFFF) drop_m++;
            exp_sig  = sig_n;
            exp_src  = src;
            exp_dst  = dst;
            exp_addr = addr;
        end
    endtask

    task automatic idle(input logic rdy);
        step('0, '0, '0, '0, rdy);
    endtask

    // Compare process: every output against the model, every cycle once out of initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rbus_out_signals", 64'(bus.rbusOut_signals), 64'(exp_sig));
            check("rbus_out_src", 64'(bus.rbusOut_src_req), 64'(exp_src));
            check("rbus_out_dst", 64'(bus.rbusOut_dst_req), 64'(exp_dst));
            check("rbus_out_addr", 64'(bus.rbusOut_address), 64'(exp_addr));
            check("in_can", 64'(bus.in_can), 64'(exp_can));
            check("deq_valid", 64'(bus.deq_valid), 64'(exp_q.size() != 0));
            check("state_capt2", 64'(state == CAPT2), 64'(waiting_second));
            if (exp_q.size() != 0) begin
                check("deq_signals", 64'(bus.deq_signals), 64'(exp_q[0].signals));
                check("deq_src", 64'(bus.deq_src_req), 64'(exp_q[0].src_req));
                check("deq_addr", 64'(bus.deq_address), 64'(exp_q[0].address));
            end
`ifdef RBUS_SINK_STATS_EN
            check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`endif
        end
    end

    initial begin
        logic [9:0]            r_dst;
        logic [RBUS_WIDTH-1:0] r_sig;
        bit                    pending;
        int                    kind;
        int                    rdy_pct;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        pending  = 1'b0;
        bus.rbusIn_signals = '0;
        bus.rbusIn_src_req = '0;
        bus.rbusIn_dst_req = '0;
        bus.rbusIn_address = '0;
        bus.deq_ready      = 1'b0;

        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_in_can", 64'(bus.in_can), 64'd1);
        check("reset_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("reset_rbus_out", 64'(bus.rbusOut_signals), 64'd0);

        // Single-beat hit.
        step(U, 10'h055, MY_DST, 37'h1234, 1'b0);
        check("single_deq_valid", 64'(bus.deq_valid), 64'd1);
        check("single_deq_addr", 64'(bus.deq_address), 64'h1234);
        check("single_fwd_used", 64'(bus.rbusOut_signals), 64'd0);
        check("single_fwd_addr", 64'(bus.rbusOut_address), 64'h1234);
        idle(1'b1);
        check("single_popped", 64'(bus.deq_valid), 64'd0);

        // Foreign destination passes through unmodified.
        step(U | 8'h40, 10'h123, MY_DST + 10'd1, 37'h5678, 1'b0);
        check("foreign_fwd_sig", 64'(bus.rbusOut_signals), 64'h41);
        check("foreign_fwd_dst", 64'(bus.rbusOut_dst_req), 64'(MY_DST + 10'd1));
        check("foreign_not_captured", 64'(bus.deq_valid), 64'd0);

        // Two-beat packet.
        step(U, 10'h001, MY_DST, 37'hA0, 1'b0);
        check("two_beat_capt2", 64'(state == CAPT2), 64'd1);
        step(U | S, 10'h001, MY_DST, 37'hA1, 1'b0);
        check("two_beat_fwd2", 64'(bus.rbusOut_signals), 64'(S));
        check("two_beat_head1", 64'(bus.deq_address), 64'hA0);
        idle(1'b1);
        check("two_beat_head2", 64'(bus.deq_address), 64'hA1);
        idle(1'b1);
        check("two_beat_empty", 64'(bus.deq_valid), 64'd0);

        // Fill to the backpressure and capacity limits.
        for (int i = 0; i < 6; i++) begin
            step(U, 10'h010, MY_DST, 37'(32'h100 + i), 1'b0);
            if (i == 4) check("fill_can_at5", 64'(bus.in_can), 64'd1);
        end
        check("fill_can_at6", 64'(bus.in_can), 64'd0);
        step(U, 10'h010, MY_DST, 37'h106, 1'b0);
        check("fill_7th_captured", 64'(bus.rbusOut_signals), 64'd0);
        step(U, 10'h010, MY_DST, 37'h107, 1'b0);
        check("fill_8th_recirc", 64'(bus.rbusOut_signals), 64'(U));
`ifdef RBUS_SINK_STATS_EN
        check("fill_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("fill_drained", 64'(bus.deq_valid), 64'd0);

        // Simultaneous push/pop at count 3 across pointer wrap.
        for (int i = 0; i < 10; i++) step(U, 10'h020, MY_DST, 37'(i), (i >= 3));
        check("wrap_head", 64'(bus.deq_address), 64'd7);
        check("wrap_in_can", 64'(bus.in_can), 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset while a second beat is awaited.
        for (int i = 0; i < 4; i++) step(U, 10'h030, MY_DST, 37'(i), 1'b0);
        step(U, 10'h030, MY_DST, 37'h4, 1'b0);
        check("rst_mid_capt2", 64'(state == CAPT2), 64'd1);
        rst = 1'b1;
        step(U | S, 10'h030, MY_DST, 37'h5, 1'b0);
        rst = 1'b0;
        check("rst_mid_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("rst_mid_in_can", 64'(bus.in_can), 64'd1);
        check("rst_mid_rbus_out", 64'(bus.rbusOut_address), 64'd0);
        check("rst_mid_state", 64'(state == CAPT2), 64'd0);

        // Randomized ring traffic.
        rdy_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 400 == 0) rdy_pct = $urandom_range(0, 100);
            rst = (cyc == 1500);
            r_sig = RBUS_WIDTH'($urandom);
            r_dst = 10'($urandom_range(0, 1023));
            if (pending) begin
                pending = 1'b0;
                step(r_sig | U | S, 10'($urandom), MY_DST, 37'({$urandom, $urandom}),
                     ($urandom_range(0, 99) < rdy_pct));
            end else begin
                kind = $urandom_range(0, 9);
                if (kind <= 1) begin
                    r_sig &= ~U;
                end else if (kind <= 3) begin
                    r_sig |= U;
                    if (r_dst == MY_DST) r_dst = r_dst + 10'd1;
                end else if (kind <= 6) begin
                    r_sig = (r_sig | U) & ~S;
                    r_dst = MY_DST;
                end else if (kind <= 8) begin
                    r_sig = (r_sig | U) & ~S;
                    r_dst = MY_DST;
                    pending = 1'b1;
                end else begin
                    r_sig |= U | S;
                    r_dst = MY_DST;
                end
                step(r_sig, 10'($urandom), r_dst, 37'({$urandom, $urandom}),
                     ($urandom_range(0, 99) < rdy_pct));
            end
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        check("final_drained", 64'(bus.deq_valid), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
